// File: rtl/instr_mem_ctrl.sv
// Clocked instruction memory with registered fetch port and streaming loader.
// Define IMEM_PARITY_EN to store and check an even-parity bit per word.
module instr_mem_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_W-1:0]     fetch_adr,
  input  logic                  fetch_stall,
  output logic [DATA_W-1:0]     instr,
  output logic                  instr_valid,
  output logic                  fetch_fault,
  output logic                  parity_err,
  input  logic                  load_start,
  input  logic [ADDR_W-1:0]     load_base,
  input  logic [DEPTH_LOG2:0]   load_count,
  input  logic                  load_valid,
  input  logic [DATA_W-1:0]     load_data,
  output logic                  load_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state;
  // One spare bit so the pointer never wraps back into range.
  logic [ADDR_W:0]       ptr;
  logic [DEPTH_LOG2:0]   remaining;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  wr_en;
  logic                  wr_inrng;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  rd_inrng;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_perr;
  logic                  fetch_go;

  assign load_ready = (state == LOAD);
  assign load_busy  = (state != IDLE);
  assign load_done  = (state == DONE);

  assign wr_en    = (state == LOAD) && load_valid;
  assign wr_inrng = (ptr >> DEPTH_LOG2) == '0;
  assign wr_idx   = ptr[DEPTH_LOG2-1:0];
  assign rd_inrng = (fetch_adr >> DEPTH_LOG2) == '0;
  assign rd_idx   = fetch_adr[DEPTH_LOG2-1:0];

  assign fetch_go = (state == IDLE) && !fetch_stall
                  && fetch_req && !load_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      load_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_start) begin
            if (load_count != '0) begin
              state     <= LOAD;
              ptr       <= {1'b0, load_base};
              remaining <= load_count;
              load_err  <= 1'b0;
            end else begin
              state <= DONE;
            end
          end
        end
        LOAD: begin
          if (load_valid) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (!wr_inrng)
              load_err <= 1'b1;
            if (remaining == 1)
              state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_inrng)
      mem[wr_idx] <= load_data;
  end

`ifdef IMEM_PARITY_EN
  logic par [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && wr_inrng)
      par[wr_idx] <= ^load_data;
  end

  assign rd_perr = (^mem[rd_idx]) ^ par[rd_idx];
`else
  assign rd_perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      parity_err  <= 1'b0;
    end else if (state != IDLE) begin
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      parity_err  <= 1'b0;
    end else if (!fetch_stall) begin
      if (fetch_go) begin
        instr_valid <= 1'b1;
        if (rd_inrng) begin
          instr       <= mem[rd_idx];
          fetch_fault <= 1'b0;
          parity_err  <= rd_perr;
        end else begin
          instr       <= '0;
          fetch_fault <= 1'b1;
          parity_err  <= 1'b0;
        end
      end else begin
        instr_valid <= 1'b0;
        fetch_fault <= 1'b0;
        parity_err  <= 1'b0;
      end
    end
  end

endmodule
